dm_responder: RTL and testbench

Responder side of the controller's data-memory strobe interface. It accepts single-cycle `enable_dm`/`enable_dm_fetch`/`enable_dm_write` requests, inserts a configurable number of wait states, then performs the read or write on an internal array. It returns a one-cycle `dm_ready` acknowledge with data and error status. It replaces the zero-latency DM model in the P5 datapath so the controller can be exercised against slow memory.

---
 rtl/dm_pkg.sv | 19 +
 rtl/dm_responder_if.sv | 29 ++
 rtl/dm_array.sv | 22 ++
 rtl/dm_responder.sv | 134 +++++++++++++
 tb/tb_dm_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dm_state_e;

  localparam int                  CntWidth = 16;
  localparam logic [CntWidth-1:0] CntMax   = 16'hFFFF;

  // Increment that sticks at the maximum count
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Strobe-style data-memory bus between the controller and the responder.
interface dm_responder_if
  import dm_pkg::*;
#(
  parameter int MemSize  = 10,
  parameter int DataSize = 32
);
  logic                enable_dm;
  logic                enable_dm_fetch;
  logic                enable_dm_write;
  logic [MemSize-1:0]  DM_address;
  logic [DataSize-1:0] DM_in;
  logic [DataSize-1:0] DM_out;
  logic                dm_ready;
  logic                dm_busy;
  logic                dm_error;
  logic [CntWidth-1:0] read_cnt;
  logic [CntWidth-1:0] write_cnt;

  modport master (
    output enable_dm, enable_dm_fetch, enable_dm_write, DM_address, DM_in,
    input  DM_out, dm_ready, dm_busy, dm_error, read_cnt, write_cnt
  );

  modport slave (
    input  enable_dm, enable_dm_fetch, enable_dm_write, DM_address, DM_in,
    output DM_out, dm_ready, dm_busy, dm_error, read_cnt, write_cnt
  );
endinterface

// File: rtl/dm_array.sv
// Word storage: synchronous write, asynchronous read, contents never reset.
module dm_array #(
  parameter int AddrW = 10,
  parameter int DataW = 32,
  parameter int Depth = 1024
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);
  logic [DataW-1:0] mem [Depth];

  // Write port
  always_ff @(posedge clock) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts strobe requests, waits WaitStates cycles,
// then answers with a one-cycle dm_ready carrying data and error status.
module dm_responder
  import dm_pkg::*;
#(
  parameter int MemSize    = 10,
  parameter int DataSize   = 32,
  parameter int Depth      = 1024,
  parameter int WaitStates = 2
) (
  input  logic        clock,
  input  logic        reset,
  dm_responder_if.slave bus
);
  localparam logic [MemSize:0] DepthLim = (MemSize+1)'(Depth);
  localparam logic [3:0]       WaitLoad = 4'(WaitStates);

  dm_state_e           state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [MemSize-1:0]  addr_q;
  logic [DataSize-1:0] data_q;
  logic                write_q, err_q;
  logic [DataSize-1:0] dout_q;
  logic                error_q;
  logic [CntWidth-1:0] rcnt_q, wcnt_q;

  logic                req, accept, acc_err, commit;
  logic [MemSize-1:0]  src_addr;
  logic                src_err, src_read;
  logic [DataSize-1:0] arr_rdata, rd_data;

  // Request decode and response-source selection
  always_comb begin
    req     = bus.enable_dm & (bus.enable_dm_fetch | bus.enable_dm_write);
    // A request held through RESP is taken on the edge that ends RESP
    accept  = req & ((state_q == IDLE) | (state_q == RESP));
    acc_err = (bus.enable_dm_fetch & bus.enable_dm_write) |
              ({1'b0, bus.DM_address} >= DepthLim);
    commit  = (state_q == RESP) & write_q & ~err_q;
    // With zero wait states the response loads on the accept edge itself,
    // so it must come straight from the bus rather than from the latches
    src_addr = accept ? bus.DM_address : addr_q;
    src_err  = accept ? acc_err : err_q;
    src_read = accept ? ~bus.enable_dm_write : ~write_q;
    // A write committing on this edge must be visible to a read loading now
    rd_data  = (commit && (addr_q == src_addr)) ? data_q : arr_rdata;
  end

  // Next-state logic and wait counter
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) state_d = IDLE;
        if (accept) begin
          wait_d  = WaitLoad;
          state_d = (WaitLoad == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, wait counter and request latches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        addr_q  <= bus.DM_address;
        data_q  <= bus.DM_in;
        write_q <= bus.enable_dm_write;
        err_q   <= acc_err;
      end
    end
  end

  // Response data/error, loaded on entry to RESP; error clears on exit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_q  <= '0;
      error_q <= 1'b0;
    end else if (state_d == RESP) begin
      error_q <= src_err;
      if (src_err)       dout_q <= '0;
      else if (src_read) dout_q <= rd_data;
    end else if (state_q == RESP) begin
      error_q <= 1'b0;
    end
  end

  // Completed-access counters, stepped as a good response retires
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt_q <= '0;
      wcnt_q <= '0;
    end else if ((state_q == RESP) && !err_q) begin
      if (write_q) wcnt_q <= sat_inc(wcnt_q);
      else         rcnt_q <= sat_inc(rcnt_q);
    end
  end

  dm_array #(
    .AddrW (MemSize),
    .DataW (DataSize),
    .Depth (Depth)
  ) u_array (
    .clock   (clock),
    .we_i    (commit),
    .waddr_i (addr_q),
    .wdata_i (data_q),
    .raddr_i (src_addr),
    .rdata_o (arr_rdata)
  );

  assign bus.DM_out    = dout_q;
  assign bus.dm_ready  = (state_q == RESP);
  assign bus.dm_busy   = (state_q != IDLE);
  assign bus.dm_error  = error_q;
  assign bus.read_cnt  = rcnt_q;
  assign bus.write_cnt = wcnt_q;
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with a response scoreboard.
// Instance A: Depth=1000, WaitStates=2.  Instance B: Depth=1024, WaitStates=0.
module tb_dm_responder;
  import dm_pkg::*;

  typedef struct {
    string       tag;
    int          exp_cyc;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  resp_t       sb_a[$];
  resp_t       sb_b[$];
  logic [31:0] mdl_a[int];
  logic [31:0] mdl_b[int];
  int          erd[2];
  int          ewr[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder_if #(.MemSize(10), .DataSize(32)) bus_a ();
  dm_responder_if #(.MemSize(10), .DataSize(32)) bus_b ();

  dm_responder #(.MemSize(10), .DataSize(32), .Depth(1000), .WaitStates(2)) dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  dm_responder #(.MemSize(10), .DataSize(32), .Depth(1024), .WaitStates(0)) dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(int sel, logic en, logic f, logic w, logic [9:0] a, logic [31:0] d);
    if (sel == 0) begin
      bus_a.enable_dm = en; bus_a.enable_dm_fetch = f; bus_a.enable_dm_write = w;
      bus_a.DM_address = a; bus_a.DM_in = d;
    end else begin
      bus_b.enable_dm = en; bus_b.enable_dm_fetch = f; bus_b.enable_dm_write = w;
      bus_b.DM_address = a; bus_b.DM_in = d;
    end
  endtask

  // Called at a negedge: drives a request for one cycle, and records the
  // expected response when one should come back.
  task automatic issue(int sel, logic f, logic w, logic [9:0] a, logic [31:0] d,
                       bit expect_resp, string tag);
    resp_t e;
    int depth = (sel == 0) ? 1000 : 1024;
    int ws    = (sel == 0) ? 2 : 0;
    drive(sel, 1'b1, f, w, a, d);
    if (expect_resp) begin
      e.tag      = tag;
      e.exp_cyc  = cyc + 1 + ws;
      e.err      = (f & w) | (int'(a) >= depth);
      e.chk_data = e.err | ~w;
      e.data     = '0;
      if (!e.err) begin
        if (w) begin
          if (sel == 0) mdl_a[int'(a)] = d; else mdl_b[int'(a)] = d;
          ewr[sel]++;
        end else begin
          e.data = (sel == 0) ? mdl_a[int'(a)] : mdl_b[int'(a)];
          erd[sel]++;
        end
      end
      if (sel == 0) sb_a.push_back(e); else sb_b.push_back(e);
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  // Waits (bounded) until all expected responses arrived, then one more
  // cycle so the counters reflect the retired access.
  task automatic wait_done(int sel);
    int n;
    for (int i = 0; i < 40; i++) begin
      n = (sel == 0) ? sb_a.size() : sb_b.size();
      if (n == 0) break;
      @(negedge clk);
    end
    n = (sel == 0) ? sb_a.size() : sb_b.size();
    chk((sel == 0) ? "a_pending_responses" : "b_pending_responses", n, 0);
    @(negedge clk);
  endtask

  task automatic chk_cnt(int sel);
    if (sel == 0) begin
      chk("a_read_cnt", bus_a.read_cnt, erd[0]);
      chk("a_write_cnt", bus_a.write_cnt, ewr[0]);
    end else begin
      chk("b_read_cnt", bus_b.read_cnt, erd[1]);
      chk("b_write_cnt", bus_b.write_cnt, ewr[1]);
    end
  endtask

  task automatic check_resp(int sel);
    resp_t e;
    int n = (sel == 0) ? sb_a.size() : sb_b.size();
    chk((sel == 0) ? "a_ready_expected" : "b_ready_expected", n > 0, 1);
    if (n > 0) begin
      if (sel == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
      chk({e.tag, "_latency"}, cyc, e.exp_cyc);
      chk({e.tag, "_error"}, (sel == 0) ? bus_a.dm_error : bus_b.dm_error, e.err);
      if (e.chk_data)
        chk({e.tag, "_data"}, (sel == 0) ? bus_a.DM_out : bus_b.DM_out, e.data);
      $display("resp %s cyc=%0d err=%b data=%h", e.tag, cyc,
               (sel == 0) ? bus_a.dm_error : bus_b.dm_error,
               (sel == 0) ? bus_a.DM_out : bus_b.DM_out);
    end
  endtask

  // Response monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (bus_a.dm_ready === 1'b1) check_resp(0);
    if (bus_b.dm_ready === 1'b1) check_resp(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_a_ready", bus_a.dm_ready, 0);
    chk("rst_a_busy", bus_a.dm_busy, 0);
    chk("rst_a_error", bus_a.dm_error, 0);
    chk("rst_a_dout", bus_a.DM_out, 0);
    chk_cnt(0);
    chk("rst_b_busy", bus_b.dm_busy, 0);
    chk("rst_b_dout", bus_b.DM_out, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // Write then read back, WaitStates=2
    issue(0, 1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b1, "a_wr5");
    wait_done(0);
    issue(0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b1, "a_rd5");
    wait_done(0);
    chk_cnt(0);

    // Out-of-range read (Depth=1000)
    issue(0, 1'b1, 1'b0, 10'd1023, 32'd0, 1'b1, "a_rd1023");
    wait_done(0);
    chk_cnt(0);

    // Fetch and write together: error, no array write
    issue(0, 1'b0, 1'b1, 10'd3, 32'h1, 1'b1, "a_wr3");
    wait_done(0);
    issue(0, 1'b1, 1'b1, 10'd3, 32'hBAD0BAD0, 1'b1, "a_conflict3");
    wait_done(0);
    issue(0, 1'b1, 1'b0, 10'd3, 32'd0, 1'b1, "a_rd3");
    wait_done(0);
    chk_cnt(0);

    // Request while busy is dropped
    issue(0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b1, "a_rd5_first");
    chk("a_busy_in_wait", bus_a.dm_busy, 1);
    issue(0, 1'b0, 1'b1, 10'd5, 32'h0, 1'b0, "a_wr5_dropped");
    wait_done(0);
    repeat (4) @(negedge clk);
    issue(0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b1, "a_rd5_again");
    wait_done(0);
    chk_cnt(0);

    // enable_dm without op, and op without enable_dm: both ignored
    drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 10'd5, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    chk("a_noop_busy", bus_a.dm_busy, 0);
    repeat (4) @(negedge clk);

    // WaitStates=0: write, then read held during the write's RESP
    issue(1, 1'b0, 1'b1, 10'd7, 32'hA5, 1'b1, "b_wr7");
    issue(1, 1'b1, 1'b0, 10'd7, 32'd0, 1'b1, "b_rd7");
    wait_done(1);
    chk_cnt(1);

    // Reset during WAIT discards an in-flight write
    issue(0, 1'b0, 1'b1, 10'd9, 32'h12, 1'b1, "a_wr9_old");
    wait_done(0);
    issue(0, 1'b0, 1'b1, 10'd9, 32'hFF, 1'b0, "a_wr9_aborted");
    chk("a_busy_before_rst", bus_a.dm_busy, 1);
    rst_a = 1'b0;
    #1;
    erd[0] = 0;
    ewr[0] = 0;
    chk("a_midrst_ready", bus_a.dm_ready, 0);
    chk("a_midrst_busy", bus_a.dm_busy, 0);
    chk("a_midrst_error", bus_a.dm_error, 0);
    chk("a_midrst_dout", bus_a.DM_out, 0);
    chk_cnt(0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, 1'b1, 1'b0, 10'd9, 32'd0, 1'b1, "a_rd9");
    wait_done(0);
    chk_cnt(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
